ur_burst_fetch: RTL and testbench

Command-driven burst reader that sits directly upstream of the user-register model. It walks a window of user registers through the `ur_re`/`ur_addr`/`ur_rdata` read port and packs the data into an address-tagged valid/ready beat stream for the store path. A small internal FIFO absorbs downstream backpressure, so register reads are issued only when the FIFO has space.

---
 rtl/ur_burst_fetch_if.sv | 42 ++++
 rtl/ur_burst_fetch.sv | 138 +++++++++++++
 tb/tb_ur_burst_fetch.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ur_burst_fetch_if.sv
`default_nettype none
// ============================================================================
// Module      : ur_burst_fetch_if
// Description : Command, user-register read and beat-stream bundle for the
//               ur_burst_fetch block.
// Revision    : 1.0 - initial release
// ============================================================================
interface ur_burst_fetch_if #(
    parameter int DATA_WIDTH     = 128,
    parameter int UR_ADDR_WIDTH  = 11,
    parameter int LEN_WIDTH      = 8,
    parameter int DST_ADDR_WIDTH = 32
);
    logic                      cmd_valid;
    logic                      cmd_ready;
    logic [UR_ADDR_WIDTH-1:0]  cmd_ur_addr;
    logic [LEN_WIDTH-1:0]      cmd_len;
    logic [DST_ADDR_WIDTH-1:0] cmd_dst_addr;
    logic                      ur_re;
    logic [UR_ADDR_WIDTH-1:0]  ur_addr;
    logic [DATA_WIDTH-1:0]     ur_rdata;
    logic                      out_valid;
    logic                      out_ready;
    logic [DATA_WIDTH-1:0]     out_data;
    logic [DST_ADDR_WIDTH-1:0] out_addr;
    logic                      out_last;
    logic                      done;
    logic                      busy;

    modport master (
        input  cmd_valid, cmd_ur_addr, cmd_len, cmd_dst_addr, ur_rdata, out_ready,
        output cmd_ready, ur_re, ur_addr, out_valid, out_data, out_addr, out_last,
               done, busy
    );

    modport slave (
        output cmd_valid, cmd_ur_addr, cmd_len, cmd_dst_addr, ur_rdata, out_ready,
        input  cmd_ready, ur_re, ur_addr, out_valid, out_data, out_addr, out_last,
               done, busy
    );
endinterface
`default_nettype wire

// File: rtl/ur_burst_fetch.sv
`default_nettype none
// ============================================================================
// Module      : ur_burst_fetch
// Description : Reads a window of user registers and emits them as an
//               address-tagged beat stream through a small beat FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module ur_burst_fetch #(
    parameter int DATA_WIDTH     = 128,
    parameter int UR_ADDR_WIDTH  = 11,
    parameter int LEN_WIDTH      = 8,
    parameter int DST_ADDR_WIDTH = 32,
    parameter int FIFO_DEPTH     = 4
) (
    input  wire logic         clk,
    input  wire logic         rst,
    ur_burst_fetch_if.master  bus
);
    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0]        c_FULL       = c_CNT_W'(FIFO_DEPTH);
    localparam logic [c_CNT_W-1:0]        c_CNT_ONE    = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0]        c_PTR_ONE    = c_PTR_W'(1);
    localparam logic [LEN_WIDTH:0]        c_LEN_ONE    = (LEN_WIDTH + 1)'(1);
    localparam logic [UR_ADDR_WIDTH-1:0]  c_UR_ONE     = UR_ADDR_WIDTH'(1);
    localparam logic [DST_ADDR_WIDTH-1:0] c_BEAT_BYTES = DST_ADDR_WIDTH'(DATA_WIDTH / 8);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_READ  = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    logic [1:0]                r_state;
    logic [1:0]                w_state_nxt;
    logic [UR_ADDR_WIDTH-1:0]  r_ur_addr;
    logic [LEN_WIDTH:0]        r_len;
    logic [LEN_WIDTH:0]        r_rd_cnt;
    logic [DST_ADDR_WIDTH-1:0] r_dst_addr;

    logic [DATA_WIDTH-1:0]     r_mem_data [FIFO_DEPTH];
    logic [DST_ADDR_WIDTH-1:0] r_mem_addr [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]     r_mem_last;
    logic [c_PTR_W-1:0]        r_wptr;
    logic [c_PTR_W-1:0]        r_rptr;
    logic [c_CNT_W-1:0]        r_count;

    logic w_valid;
    logic w_cmd_fire;
    logic w_rd;
    logic w_rd_last;
    logic w_pop;

    always_comb begin
        w_valid     = (r_count != '0);
        w_cmd_fire  = (r_state == c_ST_IDLE) && bus.cmd_valid && !rst;
        // Space is judged on the registered count only; a pop this cycle does not help.
        w_rd        = (r_state == c_ST_READ) && (r_count != c_FULL);
        w_rd_last   = (r_rd_cnt == (r_len - c_LEN_ONE));
        w_pop       = w_valid && bus.out_ready;
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_cmd_fire) begin
                    w_state_nxt = (bus.cmd_len == '0) ? c_ST_DONE : c_ST_READ;
                end
            end
            c_ST_READ: begin
                if (w_rd && w_rd_last) begin
                    w_state_nxt = c_ST_DRAIN;
                end
            end
            c_ST_DRAIN: begin
                if (w_pop && r_mem_last[r_rptr]) begin
                    w_state_nxt = c_ST_DONE;
                end
            end
            c_ST_DONE: w_state_nxt = c_ST_IDLE;
            default:   w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_ur_addr  <= '0;
            r_len      <= '0;
            r_rd_cnt   <= '0;
            r_dst_addr <= '0;
            r_mem_last <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_cmd_fire) begin
                r_ur_addr  <= bus.cmd_ur_addr;
                r_len      <= {1'b0, bus.cmd_len};
                r_rd_cnt   <= '0;
                r_dst_addr <= bus.cmd_dst_addr;
            end else if (w_rd) begin
                r_ur_addr  <= r_ur_addr + c_UR_ONE;
                r_rd_cnt   <= r_rd_cnt + c_LEN_ONE;
                r_dst_addr <= r_dst_addr + c_BEAT_BYTES;
            end
            if (w_rd) begin
                r_mem_last[r_wptr] <= w_rd_last;
                r_wptr             <= r_wptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PTR_ONE;
            end
            case ({w_rd, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage needs no reset; the head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_rd) begin
            r_mem_data[r_wptr] <= bus.ur_rdata;
            r_mem_addr[r_wptr] <= r_dst_addr;
        end
    end

    assign bus.cmd_ready = (r_state == c_ST_IDLE) && !rst;
    assign bus.ur_re     = w_rd;
    assign bus.ur_addr   = r_ur_addr;
    assign bus.out_valid = w_valid;
    assign bus.out_data  = w_valid ? r_mem_data[r_rptr] : '0;
    assign bus.out_addr  = w_valid ? r_mem_addr[r_rptr] : '0;
    assign bus.out_last  = w_valid && r_mem_last[r_rptr];
    assign bus.done      = (r_state == c_ST_DONE);
    assign bus.busy      = (r_state != c_ST_IDLE);
endmodule
`default_nettype wire

// File: tb/tb_ur_burst_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_ur_burst_fetch
// Description : Directed, model-checked bench for ur_burst_fetch.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ur_burst_fetch;
    localparam int c_DEPTH = 4;

    typedef struct packed {
        logic [10:0]  ua;
        logic [127:0] d;
        logic [31:0]  a;
        logic         l;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    ur_burst_fetch_if bus ();

    ur_burst_fetch dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [127:0] pat(input logic [10:0] a);
        return {32'hDEAD0000 | 32'(a), 32'(a) * 32'h00010001, ~32'(a), 32'h5A5A5A5A ^ 32'(a)};
    endfunction

    assign bus.ur_rdata = pat(bus.ur_addr);

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Transaction-level model: expected reads, buffered beats, completion timing
    beat_t exp_rd[$];
    beat_t fifo_q[$];
    beat_t b;
    int    occ;
    bit    m_active = 1'b0;
    int    m_start = 0;
    int    m_done_at = -1;
    int    n_reads = 0, n_pops = 0, done_cnt = 0, busy_cnt = 0;
    int    acc_log[$], done_log[$], rd_cyc_log[$];
    logic [10:0]  rd_addr_log[$];
    logic [31:0]  pop_addr_log[$];
    logic [127:0] pop_data_log[$];

    always @(negedge clk) begin
        if (rst) begin
            exp_rd.delete();
            fifo_q.delete();
            m_active = 1'b0;
            check("rst_cmd_ready", bus.cmd_ready, 0);
        end else begin
            occ = fifo_q.size();
            check("cmd_ready", bus.cmd_ready, !m_active);
            check("busy", bus.busy, m_active && cyc >= m_start);
            check("done", bus.done, m_active && cyc == m_done_at);
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                done_cnt++;
                done_log.push_back(cyc);
            end
            if (m_active && cyc == m_done_at) m_active = 1'b0;
            check("out_valid", bus.out_valid, occ != 0);
            if (bus.out_valid && occ != 0) begin
                b = fifo_q[0];
                check("out_data", bus.out_data, b.d);
                check("out_addr", bus.out_addr, b.a);
                check("out_last", bus.out_last, b.l);
                if (bus.out_ready) begin
                    void'(fifo_q.pop_front());
                    n_pops++;
                    pop_addr_log.push_back(bus.out_addr);
                    pop_data_log.push_back(bus.out_data);
                    if (b.l) m_done_at = cyc + 1;
                end
            end
            if (bus.ur_re) begin
                n_reads++;
                rd_addr_log.push_back(bus.ur_addr);
                rd_cyc_log.push_back(cyc);
                if (exp_rd.size() == 0) begin
                    check("unexpected_ur_re", 1, 0);
                end else begin
                    b = exp_rd.pop_front();
                    check("ur_addr", bus.ur_addr, b.ua);
                    check("rd_fifo_space", occ < c_DEPTH, 1);
                    fifo_q.push_back(b);
                end
            end
            if (bus.cmd_valid && bus.cmd_ready) begin
                acc_log.push_back(cyc);
                m_active  = 1'b1;
                m_start   = cyc + 1;
                m_done_at = (bus.cmd_len == 0) ? cyc + 1 : -1;
                for (int n = 0; n < int'(bus.cmd_len); n++) begin
                    b.ua = bus.cmd_ur_addr + 11'(n);
                    b.d  = pat(b.ua);
                    b.a  = bus.cmd_dst_addr + 32'(n * 16);
                    b.l  = (n == int'(bus.cmd_len) - 1);
                    exp_rd.push_back(b);
                end
            end
        end
    end

    task automatic send_cmd(input logic [10:0] a, input logic [7:0] len,
                            input logic [31:0] d, input bit keep);
        bit ok;
        ok = 1'b0;
        bus.cmd_valid    = 1'b1;
        bus.cmd_ur_addr  = a;
        bus.cmd_len      = len;
        bus.cmd_dst_addr = d;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (bus.cmd_ready) ok = 1'b1;
        end
        if (!ok) check("cmd_accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        if (!keep) bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (bus.cmd_ready) ok = 1'b1;
        end
        if (!ok) check("idle_timeout", 0, 1);
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    int base_r, base_p, base_d, base_b, base_a;
    bit idle;

    initial begin
        bus.cmd_valid    = 1'b0;
        bus.cmd_ur_addr  = '0;
        bus.cmd_len      = '0;
        bus.cmd_dst_addr = '0;
        bus.out_ready    = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ur_re", bus.ur_re, 0);
        check("reset_out_valid", bus.out_valid, 0);
        check("reset_busy", bus.busy, 0);
        sync();
        rst = 1'b0;

        // Basic burst
        sync();
        base_r = rd_addr_log.size(); base_p = pop_addr_log.size(); base_a = acc_log.size();
        send_cmd(11'h010, 8'd4, 32'h0000_1000, 1'b0);
        wait_idle();
        check("basic_rd0", rd_addr_log[base_r], 11'h010);
        check("basic_rd3", rd_addr_log[base_r + 3], 11'h013);
        check("basic_rd_cyc", rd_cyc_log[base_r] - acc_log[base_a], 1);
        check("basic_addr0", pop_addr_log[base_p], 32'h0000_1000);
        check("basic_addr1", pop_addr_log[base_p + 1], 32'h0000_1010);
        check("basic_addr3", pop_addr_log[base_p + 3], 32'h0000_1030);
        check("basic_data0", pop_data_log[base_p],
              128'hDEAD0010_00100010_FFFFFFEF_5A5A5A4A);
        check("basic_done_cyc", done_log[done_log.size() - 1] - acc_log[base_a], 6);

        // Backpressure
        sync();
        bus.out_ready = 1'b0;
        base_r = n_reads; base_p = n_pops;
        send_cmd(11'h100, 8'd10, 32'h0000_2000, 1'b0);
        repeat (8) @(posedge clk);
        check("bp_reads_stalled", n_reads - base_r, 4);
        #1;
        idle = 1'b0;
        for (int i = 0; i < 200 && !idle; i++) begin
            bus.out_ready = !bus.out_ready;
            @(negedge clk);
            if (bus.cmd_ready) idle = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!idle) check("bp_timeout", 0, 1);
        bus.out_ready = 1'b1;
        check("bp_reads", n_reads - base_r, 10);
        check("bp_beats", n_pops - base_p, 10);

        // Address wrap
        sync();
        base_r = rd_addr_log.size(); base_p = pop_addr_log.size();
        send_cmd(11'h7FE, 8'd4, 32'hFFFF_FFE0, 1'b0);
        wait_idle();
        check("wrap_rd1", rd_addr_log[base_r + 1], 11'h7FF);
        check("wrap_rd2", rd_addr_log[base_r + 2], 11'h000);
        check("wrap_rd3", rd_addr_log[base_r + 3], 11'h001);
        check("wrap_addr1", pop_addr_log[base_p + 1], 32'hFFFF_FFF0);
        check("wrap_addr2", pop_addr_log[base_p + 2], 32'h0000_0000);
        check("wrap_addr3", pop_addr_log[base_p + 3], 32'h0000_0010);

        // Zero length
        sync();
        base_r = n_reads; base_p = n_pops; base_b = busy_cnt; base_a = acc_log.size();
        send_cmd(11'h055, 8'd0, 32'h0000_3000, 1'b0);
        wait_idle();
        check("zero_reads", n_reads - base_r, 0);
        check("zero_beats", n_pops - base_p, 0);
        check("zero_busy_cycles", busy_cnt - base_b, 1);
        check("zero_done_cyc", done_log[done_log.size() - 1] - acc_log[base_a], 1);

        // Reset mid-burst
        sync();
        base_p = n_pops; base_d = done_cnt;
        send_cmd(11'h200, 8'd8, 32'h0000_4000, 1'b0);
        idle = 1'b0;
        for (int i = 0; i < 100 && !idle; i++) begin
            @(negedge clk);
            if (n_pops - base_p >= 3) idle = 1'b1;
        end
        if (!idle) check("mid_beats_timeout", 0, 1);
        sync();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_ur_re", bus.ur_re, 0);
        check("mid_rst_ur_addr", bus.ur_addr, 0);
        check("mid_rst_out_valid", bus.out_valid, 0);
        check("mid_rst_out_data", bus.out_data, 0);
        check("mid_rst_out_addr", bus.out_addr, 0);
        check("mid_rst_out_last", bus.out_last, 0);
        check("mid_rst_done", bus.done, 0);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_cmd_ready", bus.cmd_ready, 0);
        sync();
        rst = 1'b0;
        @(negedge clk);
        check("mid_ready_after_rst", bus.cmd_ready, 1);
        check("mid_no_done", done_cnt - base_d, 0);
        sync();
        base_p = n_pops;
        send_cmd(11'h300, 8'd2, 32'h0000_5000, 1'b0);
        wait_idle();
        check("mid_fresh_beats", n_pops - base_p, 2);
        check("mid_fresh_done", done_cnt - base_d, 1);

        // Back-to-back commands
        sync();
        base_p = pop_addr_log.size(); base_d = done_cnt; base_a = acc_log.size();
        send_cmd(11'h020, 8'd3, 32'h0000_6000, 1'b1);
        send_cmd(11'h040, 8'd1, 32'h0000_7000, 1'b0);
        wait_idle();
        check("b2b_accept_gap", acc_log[base_a + 1] - acc_log[base_a], 6);
        check("b2b_done", done_cnt - base_d, 2);
        check("b2b_addr2", pop_addr_log[base_p + 2], 32'h0000_6020);
        check("b2b_addr3", pop_addr_log[base_p + 3], 32'h0000_7000);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
